// File: rtl/seg7_parity_scan.sv
// Multiplexed N-digit hex 7-segment driver with per-digit parity checking.
// Captured digits with a parity error show a dash; bad loads are counted.
module seg7_parity_scan #(
  parameter int N_DIGITS   = 4,
  parameter int PARITY_ODD = 0,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   par,
  input  logic                  clr_err,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic [N_DIGITS-1:0]   err_flags,
  output logic [7:0]            err_cnt
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [15:0]   PSC_MAX = 16'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  localparam logic [6:0]    DASH    = 7'b1000000;

  logic [4*N_DIGITS-1:0] dig_q;
  logic [N_DIGITS-1:0]   bad;
  logic [15:0]           psc;
  logic [IW-1:0]         idx;
  logic [3:0]            cur_nib;
  logic                  cur_err;

  always_comb begin
    bad = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      bad[i] = ^{data[4*i +: 4], par[i]} ^ 1'(PARITY_ODD);
    end
  end

  // Digit currently selected by the pre-edge index; feeds the registered seg.
  always_comb begin
    cur_nib = dig_q[4*idx +: 4];
    cur_err = err_flags[idx];
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'b0000000;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'ha: s = 7'b1110111;
      4'hb: s = 7'b1111100;
      4'hc: s = 7'b0111001;
      4'hd: s = 7'b1011110;
      4'he: s = 7'b1111001;
      4'hf: s = 7'b1110001;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q     <= '0;
      err_flags <= '0;
    end else if (load) begin
      dig_q     <= data;
      err_flags <= bad;
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (clr_err) begin
      err_cnt <= 8'd0;
    end else if (load && (|bad) && (err_cnt != 8'hff)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  // an and seg are both taken from the pre-edge index so they always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
      idx <= '0;
      an  <= '0;
      seg <= '0;
    end else if (en) begin
      an  <= N_DIGITS'(1) << idx;
      seg <= cur_err ? DASH : hex7(cur_nib);
      if (psc == PSC_MAX) begin
        psc <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        psc <= psc + 16'd1;
      end
    end else begin
      an  <= '0;
      seg <= '0;
    end
  end

endmodule

// File: tb/tb_seg7_parity_scan.sv
// Bench for seg7_parity_scan: cycle model feeding an expected queue plus
// directed spot checks of scan order, decode, parity flags, counter and reset.
module tb_seg7_parity_scan;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int PO = 0;
  localparam int W  = ND + 7 + ND + 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  par = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [3:0]  err_flags;
  logic [7:0]  err_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];
  logic [6:0] seg_tbl [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                               7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

  seg7_parity_scan #(.N_DIGITS(ND), .PARITY_ODD(PO), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data), .par(par),
    .clr_err(clr_err), .seg(seg), .an(an), .err_flags(err_flags), .err_cnt(err_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: computes post-edge outputs from pre-edge state and inputs
  logic [15:0] m_dig = '0;
  logic [3:0]  m_flags = '0;
  logic [7:0]  m_cnt = '0;
  int          m_psc = 0;
  int          m_idx = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] b;
    logic [3:0] n_an;
    logic [6:0] n_seg;
    logic [3:0] nib;
    if (!rst_n) begin
      m_dig = '0; m_flags = '0; m_cnt = '0; m_psc = 0; m_idx = 0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < ND; i++)
        b[i] = (($countones({data[4*i +: 4], par[i]}) % 2) != PO);
      nib   = m_dig[4*m_idx +: 4];
      n_an  = en ? (4'b0001 << m_idx) : 4'b0000;
      n_seg = !en ? 7'h00 : (m_flags[m_idx] ? 7'h40 : seg_tbl[nib]);
      if (en) begin
        m_psc++;
        if (m_psc == SD) begin
          m_psc = 0;
          m_idx = (m_idx + 1) % ND;
        end
      end
      if (load) begin
        m_dig   = data;
        m_flags = b;
      end
      if (clr_err) m_cnt = 8'd0;
      else if (load && (b != 4'b0) && (m_cnt != 8'd255)) m_cnt = m_cnt + 8'd1;
      exp_q.push_back({n_an, n_seg, m_flags, m_cnt});
    end
  end

  // scoreboard: compare on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("model", {an, seg, err_flags, err_cnt}, e);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic clr);
    data = d; par = p; load = 1'b1; clr_err = clr;
    tick(1);
    load = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    int guard;
    int d2;
    logic [6:0] es;

    tick(3);
    check("rst_an", an, 4'b0000);
    check("rst_seg", seg, 7'h00);
    check("rst_flags", err_flags, 4'b0000);
    check("rst_cnt", err_cnt, 8'd0);

    rst_n = 1'b1; en = 1'b1;
    tick(1);
    check("first_an", an, 4'b0001);
    check("first_seg", seg, 7'h3f);
    tick(4);
    check("step_an", an, 4'b0010);
    tick(12);
    check("wrap_an", an, 4'b0001);

    // parity bits chosen so every digit of 1A8F is even
    do_load(16'h1a8f, 4'b1010, 1'b0);
    check("good_flags", err_flags, 4'b0000);
    check("good_cnt", err_cnt, 8'd0);
    for (int k = 0; k < 16; k++) begin
      tick(1);
      case (an)
        4'b0001: es = 7'h71;
        4'b0010: es = 7'h7f;
        4'b0100: es = 7'h77;
        4'b1000: es = 7'h06;
        default: es = 7'h00;
      endcase
      check("good_digit", seg, es);
    end

    do_load(16'h0003, 4'b0001, 1'b0);
    check("bad_flags", err_flags, 4'b0001);
    check("bad_cnt", err_cnt, 8'd1);
    for (int k = 0; k < 16; k++) begin
      tick(1);
      check("bad_digit", seg, (an == 4'b0001) ? 7'h40 : 7'h3f);
    end

    load = 1'b1;
    tick(256);
    load = 1'b0;
    check("sat_cnt", err_cnt, 8'd255);
    do_load(16'h0003, 4'b0001, 1'b0);
    check("sat_hold", err_cnt, 8'd255);
    do_load(16'h0003, 4'b0001, 1'b1);
    check("clr_wins", err_cnt, 8'd0);
    do_load(16'h0003, 4'b0001, 1'b0);
    check("recount", err_cnt, 8'd1);

    // pause in the middle of digit 2
    guard = 0;
    while (an === 4'b0100 && guard < 64) begin tick(1); guard++; end
    while (an !== 4'b0100 && guard < 64) begin tick(1); guard++; end
    check("find_d2", an, 4'b0100);
    d2 = 1;
    tick(1);
    if (an === 4'b0100) d2++;
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("pause_an", an, 4'b0000);
      check("pause_seg", seg, 7'h00);
    end
    en = 1'b1;
    guard = 0;
    do begin
      tick(1);
      if (an === 4'b0100) d2++;
      guard++;
    end while (an === 4'b0100 && guard < 16);
    check("d2_total", d2, 4);
    check("after_d2", an, 4'b1000);

    // asynchronous reset mid-scan with an error latched
    do_load(16'h0003, 4'b0001, 1'b0);
    tick(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", an, 4'b0000);
    check("async_seg", seg, 7'h00);
    check("async_flags", err_flags, 4'b0000);
    check("async_cnt", err_cnt, 8'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("restart_an", an, 4'b0001);
    check("restart_seg", seg, 7'h3f);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
